// File: rtl/fetch_queue.sv
// Instruction fetch queue: owns the fetch PC, issues one word request at a time,
// buffers {pc, instr} in a circular FIFO and presents the head first-word-fall-through.
module fetch_queue #(
  parameter int unsigned   DEPTH    = 16,
  parameter int unsigned   PC_W     = 32,
  parameter int unsigned   INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  localparam int unsigned  CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  output logic               req_valid,
  output logic [PC_W-1:0]    req_addr,
  input  logic               req_ready,
  input  logic               resp_valid,
  input  logic [INSTR_W-1:0] resp_instr,
  input  logic               flush,
  input  logic [PC_W-1:0]    flush_pc,
  output logic               out_valid,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  entry_t             mem_q [DEPTH];
  logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]    pend_pc_q, pend_pc_d;
  logic               pending_q, pending_d;
  logic               discard_q, discard_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic flush_act, req_fire, resp_take, enq, deq;

  // Handshake qualifiers; flush and pause suppress both request and dequeue
  assign req_valid = rdy & ~pending_q & ~flush & (count_q < CNT_W'(DEPTH));
  assign req_addr  = fetch_pc_q;
  assign out_valid = rdy & (count_q != '0) & ~flush;
  assign out_pc    = mem_q[head_q].pc;
  assign out_instr = mem_q[head_q].instr;
  assign count     = count_q;

  assign flush_act = rdy & flush;
  assign req_fire  = req_valid & req_ready;
  assign resp_take = rdy & resp_valid & pending_q;
  assign enq       = resp_take & ~discard_q & ~flush;
  assign deq       = out_valid & out_ready;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    pend_pc_d  = pend_pc_q;
    pending_d  = pending_q;
    discard_d  = discard_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (flush_act) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      fetch_pc_d = flush_pc & ~PC_W'(3);
      // An outstanding response not arriving now must be thrown away later
      discard_d  = pending_q & ~resp_valid;
      if (resp_take) pending_d = 1'b0;
    end else if (rdy) begin
      if (req_fire) begin
        pend_pc_d  = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + PC_W'(4);
        pending_d  = 1'b1;
      end
      if (resp_take) begin
        pending_d = 1'b0;
        discard_d = 1'b0;
      end
      if (enq) tail_d = tail_q + PTR_W'(1);
      if (deq) head_d = head_q + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      pend_pc_q  <= RESET_PC;
      pending_q  <= 1'b0;
      discard_q  <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= pend_pc_d;
      pending_q  <= pending_d;
      discard_q  <= discard_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // Entry storage needs no reset; pointers and count define validity
  always_ff @(posedge clk) begin
    if (enq) mem_q[tail_q] <= '{pc: pend_pc_q, instr: resp_instr};
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized scoreboard bench for fetch_queue: a fetcher model feeds responses,
// a queue-based reference predicts the decoder stream, a monitor checks it.
module tb_fetch_queue;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned PC_W    = 32;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned CNT_W   = 3;
  localparam int          NCYC    = 3000;

  logic               clk;
  logic               rst;
  logic               rdy;
  logic               req_valid;
  logic [PC_W-1:0]    req_addr;
  logic               req_ready;
  logic               resp_valid;
  logic [INSTR_W-1:0] resp_instr;
  logic               flush;
  logic [PC_W-1:0]    flush_pc;
  logic               out_valid;
  logic [PC_W-1:0]    out_pc;
  logic [INSTR_W-1:0] out_instr;
  logic               out_ready;
  logic [CNT_W-1:0]   count;

  fetch_queue #(
    .DEPTH(DEPTH), .PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_instr(resp_instr),
    .flush(flush), .flush_pc(flush_pc),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .out_ready(out_ready), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   pops   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: consumes the expected stream whenever the DUT hands over an entry
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_dequeue", 64'(out_pc), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("out_pc", 64'(out_pc), 64'(e.pc));
          check("out_instr", 64'(out_instr), 64'(e.instr));
          pops++;
        end
      end
    end
  end

  // Reference state: next fetch address, one outstanding request, stale flag
  logic [31:0] m_pc, pend_addr;
  bit          outst, stale, saw_full;
  int          lat;

  initial begin
    bit          m_req_valid, m_out_valid, s_reqhs;
    exp_t        e;
    rst = 1'b1; rdy = 1'b0; req_ready = 1'b0; resp_valid = 1'b0; resp_instr = '0;
    flush = 1'b0; flush_pc = '0; out_ready = 1'b0;
    m_pc = 32'h0; pend_addr = '0; outst = 0; stale = 0; lat = 0; saw_full = 0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req_valid", 64'(req_valid), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_req_addr", 64'(req_addr), 64'h0);
    rst = 1'b0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      #1;
      rdy = (cyc >= 200 && cyc < 205) ? 1'b0 : (($urandom % 10) != 0);
      if (((cyc / 100) % 3) == 1) out_ready = (($urandom % 8) == 0);
      else                        out_ready = (($urandom % 4) != 0);
      flush    = (($urandom % 24) == 0);
      flush_pc = $urandom;
      if (cyc == 300) begin
        flush = 1'b1;
        flush_pc = 32'h1003;
      end
      req_ready  = (($urandom % 3) != 0);
      resp_valid = outst ? (lat == 0) : (($urandom % 16) == 0);
      resp_instr = $urandom;
      if (outst && lat > 0) lat--;
      #1;
      m_req_valid = rdy && !outst && !flush && (sb.size() < DEPTH);
      m_out_valid = rdy && (sb.size() != 0) && !flush;
      check("req_valid", 64'(req_valid), 64'(m_req_valid));
      check("out_valid", 64'(out_valid), 64'(m_out_valid));
      check("count", 64'(count), 64'(sb.size()));
      check("req_addr", 64'(req_addr), 64'(m_pc));
      if (count == CNT_W'(DEPTH)) saw_full = 1;
      s_reqhs = m_req_valid && req_ready;

      @(posedge clk);
      #1;
      if (rdy) begin
        if (flush) begin
          sb.delete();
          m_pc = flush_pc & ~32'h3;
          if (outst) begin
            if (resp_valid) begin
              outst = 0;
              stale = 0;
            end else begin
              stale = 1;
            end
          end
        end else if (outst && resp_valid) begin
          if (!stale) begin
            e.pc = pend_addr;
            e.instr = resp_instr;
            sb.push_back(e);
          end
          outst = 0;
          stale = 0;
        end else if (s_reqhs) begin
          outst = 1;
          pend_addr = m_pc;
          m_pc = m_pc + 32'd4;
          lat = $urandom_range(0, 3);
        end
      end
    end

    @(negedge clk);
    check("reached_full", 64'(saw_full), 64'd1);
    check("progress", 64'(pops > 100), 64'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
